pic_mem_reader: RTL and testbench

Sequential reader for the second port of the dual-port picture memory (1200 × 16-bit words). On a start pulse it fetches every word from address 0 to DEPTH-1 in order through the memory's second port. It buffers the words in a 4-entry FIFO and presents them as a valid/ready pixel stream to the LT24 display controller. The first port remains free for the Nios II processor to write picture data.

---
 rtl/pic_mem_reader_if.sv | 41 ++++
 rtl/pic_mem_reader.sv | 172 +++++++++++++++++
 tb/tb_pic_mem_reader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_mem_reader_if.sv
// ============================================================================
//  Module      : pic_mem_reader_if
//  Description : Bundles the picture-memory second port and the outgoing
//                valid/ready pixel stream of the picture memory reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pic_mem_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  // Picture memory, second port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [1:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  // Pixel stream towards the display controller
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_ready;
  logic              px_last;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output px_data, px_valid, px_last,
    input  px_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  px_data, px_valid, px_last,
    output px_ready
  );
endinterface

`default_nettype wire

// File: rtl/pic_mem_reader.sv
// ============================================================================
//  Module      : pic_mem_reader
//  Description : Streams one full frame (DEPTH words) out of the picture
//                memory second port through a 4-entry FIFO as a valid/ready
//                pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_mem_reader #(
  parameter int DEPTH  = 1200,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         start,
  input  wire logic         abort,
  output logic              busy,
  output logic              done,
  pic_mem_reader_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [DATA_W-1:0] r_fifo_data [4];
  logic [3:0]        r_fifo_last;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;
  logic              r_done;

  logic              w_issue;
  logic              w_finish;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_head_last;

  assign w_valid     = (r_count != 3'd0);
  assign w_head_last = r_fifo_last[r_rd_ptr];
  assign w_pop       = w_valid & bus.px_ready;
  // A read issued last cycle returns data now; abort discards it via flush.
  assign w_push      = r_inflight;
  // Flush on an accepted start (fresh frame) and on abort of a running frame.
  assign w_flush     = (r_state == S_IDLE) ? (start & ~abort) : abort;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, read issue and end-of-frame decode
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          // Keep FIFO occupancy plus the outstanding read at most 3.
          w_issue = (({1'b0, r_count} + {3'b000, r_inflight}) <= 4'd2);
          if (w_issue && (r_addr == c_last_addr)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_pop && w_head_last && !r_inflight && (r_count == 3'd1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read address counter: restarts at 0 per frame, saturates at the last word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else if (r_state == S_IDLE) begin
      if (start && !abort) r_addr <= '0;
    end else if (w_issue && (r_addr != c_last_addr)) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Track the read in flight and whether it targets the final word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (w_flush) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_addr == c_last_addr);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else if (w_flush) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: word plus its end-of-frame flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_fifo_data[i] <= '0;
      r_fifo_last <= 4'd0;
    end else if (w_push && !w_flush) begin
      r_fifo_data[r_wr_ptr] <= bus.mem_readdata;
      r_fifo_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  // One-cycle completion pulse after the final handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_done <= 1'b0;
    else          r_done <= w_finish;
  end

  assign busy               = (r_state != S_IDLE);
  assign done               = r_done;
  assign bus.mem_address    = r_addr;
  assign bus.mem_chipselect = w_issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 2'b11;
  assign bus.mem_clken      = 1'b1;
  assign bus.px_valid       = w_valid;
  assign bus.px_data        = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.px_last        = w_valid & w_head_last;

endmodule

`default_nettype wire

// File: tb/tb_pic_mem_reader.sv
// ============================================================================
//  Module      : tb_pic_mem_reader
//  Description : Directed self-checking bench for pic_mem_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_mem_reader;

  localparam int DEPTH  = 1200;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic abort   = 1'b0;
  logic busy;
  logic done;

  pic_mem_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pic_mem_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Picture memory model: one-cycle read latency on port 2
  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_chipselect && (int'(bus.mem_address) < DEPTH))
      bus.mem_readdata <= mem[bus.mem_address];
  end

  // FIFO occupancy watch
  int ovf_cnt   = 0;
  int max_count = 0;
  always @(posedge clk) begin
    if (dut.w_push && !dut.w_pop && (dut.r_count == 3'd4)) ovf_cnt <= ovf_cnt + 1;
    if (int'(dut.r_count) > max_count) max_count <= int'(dut.r_count);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_words  = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_valid"}, 32'(bus.px_valid), 32'd0);
    check({tag, "_last"},  32'(bus.px_last), 32'd0);
    check({tag, "_data"},  32'(bus.px_data), 32'd0);
    check({tag, "_addr"},  32'(bus.mem_address), 32'd0);
    check({tag, "_cs"},    32'(bus.mem_chipselect), 32'd0);
    check({tag, "_wr"},    32'(bus.mem_write), 32'd0);
    check({tag, "_be"},    32'(bus.mem_byteenable), 32'd3);
    check({tag, "_clken"}, 32'(bus.mem_clken), 32'd1);
  endtask

  task automatic start_frame(input logic [15:0] key);
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i) ^ key;
    n_words = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("first_issue_cs", 32'(bus.mem_chipselect), 32'd1);
    check("first_issue_addr", 32'(bus.mem_address), 32'd0);
  endtask

  // Consume the stream; mode 0 = ready always high, mode 1 = 30% random ready.
  // Returns on done, or when stop_at words have been handshaked.
  task automatic stream(input int mode, input logic [15:0] key, input int stop_at,
                        input int dup_start_at, input bit chk_lat, input int budget);
    int          k = 2;
    bit          seen = 0, prev_stall = 0, last_hs = 0, dup_done = 0, r;
    logic [15:0] prev_d = '0, d;
    logic        v, l, dn, b;
    for (int it = 0; it < budget; it++) begin
      @(negedge clk);
      v = bus.px_valid; d = bus.px_data; l = bus.px_last; dn = done; b = busy;
      start = 1'b0;
      if (last_hs || dn) begin
        check("done_pulse", 32'(dn), 32'(last_hs));
        if (dn) begin
          n_done++;
          check("busy_at_done", 32'(b), 32'd0);
        end
        check("frame_words", 32'(n_words), 32'(DEPTH));
        return;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(v), 32'd1);
        check("stall_data", 32'(d), 32'(prev_d));
      end
      if (v && !seen) begin
        seen = 1;
        if (chk_lat) check("first_valid_latency", 32'(k), 32'd3);
      end
      if (mode == 0 && seen) check("no_gap", 32'(v), 32'd1);
      if (n_words == stop_at) return;
      if (dup_start_at >= 0 && n_words == dup_start_at && !dup_done) begin
        start    = 1'b1;
        dup_done = 1;
      end
      r = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      bus.px_ready = r;
      if (v && r) begin
        check("px_data", 32'(d), 32'(16'(n_words) ^ key));
        check("px_last", 32'(l), 32'(n_words == DEPTH - 1));
        n_words++;
        last_hs = (n_words == DEPTH);
      end
      prev_stall = v && !r;
      prev_d     = d;
      k++;
    end
    check("stream_timeout_words", 32'(n_words), 32'((stop_at >= 0) ? stop_at : DEPTH));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          d0;
    bus.px_ready = 1'b0;

    // Reset and idle
    repeat (5) @(negedge clk);
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_no_cs", 32'(bus.mem_chipselect), 32'd0);
    end
    check_reset_vals("idle");

    // start together with abort in IDLE is ignored
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", 32'(busy), 32'd0);
    check("start_abort_idle_cs", 32'(bus.mem_chipselect), 32'd0);

    // Full-rate frame
    bus.px_ready = 1'b1;
    d0 = n_done;
    start_frame(16'h0000);
    stream(0, 16'h0000, -1, -1, 1'b1, 3000);
    check("full_done_count", 32'(n_done - d0), 32'd1);

    // Random back-pressure frame
    d0 = n_done;
    start_frame(16'hA5A5);
    stream(1, 16'hA5A5, -1, -1, 1'b0, 20000);
    check("bp_done_count", 32'(n_done - d0), 32'd1);
    check("fifo_overflow", 32'(ovf_cnt), 32'd0);
    check("fifo_max_le4", 32'(max_count <= 4), 32'd1);

    // Abort after 100 words, with 3 stalled cycles before it
    bus.px_ready = 1'b1;
    d0 = n_done;
    start_frame(16'h0000);
    stream(0, 16'h0000, 100, -1, 1'b0, 3000);
    bus.px_ready = 1'b0;
    check("abort_stall_data0", 32'(bus.px_data), 32'd100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_stall_valid", 32'(bus.px_valid), 32'd1);
      check("abort_stall_data", 32'(bus.px_data), 32'd100);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 32'(bus.px_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_abort_valid", 32'(bus.px_valid), 32'd0);
      check("post_abort_done", 32'(done), 32'd0);
      check("post_abort_cs", 32'(bus.mem_chipselect), 32'd0);
    end
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    bus.px_ready = 1'b1;
    start_frame(16'h0000);
    stream(0, 16'h0000, -1, -1, 1'b1, 3000);
    check("restart_done_count", 32'(n_done - d0), 32'd1);

    // Start while busy is ignored
    d0 = n_done;
    start_frame(16'h0000);
    stream(0, 16'h0000, -1, 500, 1'b0, 3000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dup_start_no_done", 32'(done), 32'd0);
      check("dup_start_idle", 32'(busy), 32'd0);
    end
    check("dup_start_done_count", 32'(n_done - d0), 32'd1);

    // Reset mid-frame at word 700
    d0 = n_done;
    start_frame(16'h0000);
    stream(0, 16'h0000, 700, -1, 1'b0, 3000);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid_async");
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_vals("rst_mid_release");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(done), 32'd0);
    end
    check("rst_mid_done_count", 32'(n_done - d0), 32'd0);
    start_frame(16'h0000);
    stream(0, 16'h0000, -1, -1, 1'b1, 3000);
    check("rst_restart_done_count", 32'(n_done - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
